// File: rtl/eng_fmt_tx.sv
// Formats an unsigned value as ASCII "<digits>[ <prefix><unit>]" and streams it
// one byte at a time over a valid/ready interface.
module eng_fmt_tx #(
    parameter int W  = 16,
    parameter int ND = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_value,
    input  logic [3:0]   in_scale,
    input  logic [1:0]   in_unit,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_byte,
    output logic         out_last
);

    typedef enum logic [2:0] {
        S_IDLE, S_CONV, S_DIGITS, S_SPACE, S_PREFIX, S_UNIT
    } state_t;

    state_t state, next_state;

    logic [W-1:0]    sh;
    logic [4*ND-1:0] bcd;
    logic [5:0]      cnt;
    logic [3:0]      scale;
    logic [1:0]      unit;
    logic [3:0]      dig_idx;
    logic            started;
    logic [1:0]      u_idx;

    logic            accept, emitting, free, hold_last, load, done;
    logic            has_space;
    logic [3:0]      cur_idx;
    logic [3:0]      digit;
    logic [4*ND-1:0] bcd_sel;
    logic [7:0]      emit_char;
    logic            emit_last;

    function automatic logic [4*ND-1:0] add3(input logic [4*ND-1:0] b);
        logic [4*ND-1:0] r;
        r = b;
        for (int i = 0; i < ND; i++)
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        return r;
    endfunction

    function automatic logic [3:0] lead_digit(input logic [4*ND-1:0] b);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < ND; i++)
            if (b[4*i +: 4] != 4'd0) idx = 4'(i);
        return idx;
    endfunction

    function automatic logic [7:0] prefix_char(input logic [3:0] s);
        case (s)
            4'd0:    return 8'h66; // f
            4'd1:    return 8'h70; // p
            4'd2:    return 8'h6E; // n
            4'd3:    return 8'h75; // u
            4'd4:    return 8'h6D; // m
            4'd6:    return 8'h6B; // k
            4'd7:    return 8'h4D; // M
            4'd8:    return 8'h47; // G
            default: return 8'h3F; // ?
        endcase
    endfunction

    assign in_ready  = (state == S_IDLE);
    assign accept    = in_valid && in_ready;
    assign has_space = (scale != 4'd5) || (unit != 2'd0);
    assign emitting  = (state == S_DIGITS) || (state == S_SPACE) ||
                       (state == S_PREFIX) || (state == S_UNIT);
    assign free      = !out_valid || out_ready;
    // The final byte parks in the output register until taken; nothing loads behind it.
    assign hold_last = out_valid && out_last;
    assign load      = emitting && free && !hold_last;
    assign done      = hold_last && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (accept) next_state = S_CONV;
            S_CONV:   if (cnt == 6'(W-1)) next_state = S_DIGITS;
            S_DIGITS: begin
                if (done) next_state = S_IDLE;
                else if (load && !emit_last && cur_idx == 4'd0) next_state = S_SPACE;
            end
            S_SPACE: begin
                if (done) next_state = S_IDLE;
                else if (load) next_state = (scale != 4'd5) ? S_PREFIX : S_UNIT;
            end
            S_PREFIX: begin
                if (done) next_state = S_IDLE;
                else if (load && !emit_last) next_state = S_UNIT;
            end
            S_UNIT:   if (done) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        emit_char = 8'h00;
        emit_last = 1'b0;
        cur_idx   = started ? dig_idx : lead_digit(bcd);
        bcd_sel   = bcd >> {cur_idx, 2'b00};
        digit     = bcd_sel[3:0];
        case (state)
            S_DIGITS: begin
                emit_char = 8'h30 + {4'd0, digit};
                emit_last = (cur_idx == 4'd0) && !has_space;
            end
            S_SPACE:  emit_char = 8'h20;
            S_PREFIX: begin
                emit_char = prefix_char(scale);
                emit_last = (unit == 2'd0);
            end
            S_UNIT: begin
                case (unit)
                    2'd1: begin emit_char = 8'h48; emit_last = 1'b1; end
                    2'd2: begin emit_char = 8'h46; emit_last = 1'b1; end
                    default: begin
                        emit_char = (u_idx == 2'd0) ? 8'h4F : (u_idx == 2'd1) ? 8'h68 : 8'h6D;
                        emit_last = (u_idx == 2'd2);
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh        <= '0;
            bcd       <= '0;
            cnt       <= '0;
            scale     <= '0;
            unit      <= '0;
            dig_idx   <= '0;
            started   <= 1'b0;
            u_idx     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_byte  <= 8'h00;
        end else begin
            if (accept) begin
                sh      <= in_value;
                bcd     <= '0;
                cnt     <= '0;
                scale   <= in_scale;
                unit    <= in_unit;
                dig_idx <= '0;
                started <= 1'b0;
                u_idx   <= '0;
            end
            // Double-dabble: correct each digit, then shift one value bit in.
            if (state == S_CONV) begin
                {bcd, sh} <= {add3(bcd), sh} << 1;
                cnt       <= cnt + 6'd1;
            end
            if (load) begin
                out_byte  <= emit_char;
                out_valid <= 1'b1;
                out_last  <= emit_last;
                if (state == S_DIGITS) begin
                    started <= 1'b1;
                    if (cur_idx != 4'd0) dig_idx <= cur_idx - 4'd1;
                end
                if (state == S_UNIT) u_idx <= u_idx + 2'd1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eng_fmt_tx.sv
// Directed bench for eng_fmt_tx (W=16, ND=5): record contents, latency,
// backpressure, reset behaviour.
module tb_eng_fmt_tx;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_value;
    logic [3:0]  in_scale;
    logic [1:0]  in_unit;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] cap_b[$];
    logic       cap_l[$];

    eng_fmt_tx #(.W(16), .ND(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .in_scale(in_scale), .in_unit(in_unit),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_byte(out_byte), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic [15:0] v, input logic [3:0] s, input logic [1:0] u);
        @(negedge clk);
        in_valid = 1'b1;
        in_value = v;
        in_scale = s;
        in_unit  = u;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_value = 16'hDEAD;
        in_scale = 4'hA;
        in_unit  = 2'd0;
    endtask

    // Collects one record; counts stalled cycles whose outputs changed.
    task automatic capture(input bit toggle, output int bad_stall, output bit timeout);
        bit         prev_stall;
        logic [7:0] prev_b;
        logic       prev_l;
        bit         fin;
        cap_b.delete();
        cap_l.delete();
        bad_stall  = 0;
        timeout    = 1'b1;
        prev_stall = 1'b0;
        prev_b     = 8'h00;
        prev_l     = 1'b0;
        fin        = 1'b0;
        for (int k = 0; k < 300 && !fin; k++) begin
            @(negedge clk);
            if (prev_stall && (out_valid !== 1'b1 || out_byte !== prev_b || out_last !== prev_l))
                bad_stall++;
            out_ready  = toggle ? ~out_ready : 1'b1;
            prev_stall = out_valid && !out_ready;
            prev_b     = out_byte;
            prev_l     = out_last;
            if (out_valid && out_ready) begin
                cap_b.push_back(out_byte);
                cap_l.push_back(out_last);
                if (out_last) begin
                    fin     = 1'b1;
                    timeout = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_value  = 16'd42;
        in_scale  = 4'd5;
        in_unit   = 2'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || out_byte !== 8'h00)
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b out_last=%b out_byte=%h, want 1 0 0 00",
                     in_ready, out_valid, out_last, out_byte);
        else n_pass++;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_no_accept: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_latency();
        int  lat;
        int  bad;
        bit  to;
        string exp;
        exp = "50 Ohm";
        out_ready = 1'b1;
        send(16'd50, 4'd5, 2'd3);
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL busy_after_accept: in_ready=%b want 0", in_ready);
        else n_pass++;
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat = k;
        end
        n_checks++;
        if (lat !== 17) $display("FAIL first_valid_latency: got %0d cycles, want 17", lat);
        else n_pass++;
        capture(1'b0, bad, to);
        n_checks++;
        if (to || cap_b.size() != exp.len())
            $display("FAIL ohm_len: got %0d bytes timeout=%b, want %0d", cap_b.size(), to, exp.len());
        else n_pass++;
        for (int i = 0; i < cap_b.size() && i < exp.len(); i++) begin
            n_checks++;
            if (cap_b[i] !== exp[i] || cap_l[i] !== (i == exp.len() - 1))
                $display("FAIL ohm_byte%0d: got %h last=%b, want %h last=%b",
                         i, cap_b[i], cap_l[i], exp[i], (i == exp.len() - 1));
            else n_pass++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL idle_after_last: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_records();
        logic [15:0] tv[3] = '{16'd1, 16'd10, 16'd0};
        logic [3:0]  ts[3] = '{4'd4, 4'd5, 4'd12};
        logic [1:0]  tu[3] = '{2'd1, 2'd0, 2'd2};
        string       te[3] = '{"1 mH", "10", "0 ?F"};
        int bad;
        bit to;
        for (int t = 0; t < 3; t++) begin
            send(tv[t], ts[t], tu[t]);
            capture(1'b0, bad, to);
            n_checks++;
            if (to || cap_b.size() != te[t].len())
                $display("FAIL rec%0d_len: got %0d bytes timeout=%b, want %0d",
                         t, cap_b.size(), to, te[t].len());
            else n_pass++;
            for (int i = 0; i < cap_b.size() && i < te[t].len(); i++) begin
                n_checks++;
                if (cap_b[i] !== te[t][i] || cap_l[i] !== (i == te[t].len() - 1))
                    $display("FAIL rec%0d_byte%0d: got %h last=%b, want %h last=%b",
                             t, i, cap_b[i], cap_l[i], te[t][i], (i == te[t].len() - 1));
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        int bad;
        bit to;
        string exp;
        exp = "65535 G";
        out_ready = 1'b1;
        send(16'hFFFF, 4'd8, 2'd0);
        capture(1'b1, bad, to);
        n_checks++;
        if (to || cap_b.size() != exp.len())
            $display("FAIL max_len: got %0d bytes timeout=%b, want %0d", cap_b.size(), to, exp.len());
        else n_pass++;
        n_checks++;
        if (bad !== 0) $display("FAIL stall_stable: %0d unstable stalled cycles, want 0", bad);
        else n_pass++;
        for (int i = 0; i < cap_b.size() && i < exp.len(); i++) begin
            n_checks++;
            if (cap_b[i] !== exp[i] || cap_l[i] !== (i == exp.len() - 1))
                $display("FAIL max_byte%0d: got %h last=%b, want %h last=%b",
                         i, cap_b[i], cap_l[i], exp[i], (i == exp.len() - 1));
            else n_pass++;
        end
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_record();
        bit seen;
        int stray;
        int bad;
        bit to;
        out_ready = 1'b1;
        send(16'd123, 4'd5, 2'd0);
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (out_valid && out_byte == 8'h32) seen = 1'b1;
        end
        n_checks++;
        if (!seen) $display("FAIL mid_second_digit: digit 2 not seen, got %h", out_byte);
        else n_pass++;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL mid_reset_state: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        else n_pass++;
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        n_checks++;
        if (stray !== 0) $display("FAIL mid_reset_abort: %0d stray valid cycles, want 0", stray);
        else n_pass++;
        send(16'd7, 4'd5, 2'd0);
        capture(1'b0, bad, to);
        n_checks++;
        if (to || cap_b.size() != 1 || cap_b[0] !== 8'h37 || cap_l[0] !== 1'b1)
            $display("FAIL after_reset_rec: got %0d bytes first=%h timeout=%b, want 1 byte 37 last",
                     cap_b.size(), (cap_b.size() > 0) ? cap_b[0] : 8'hXX, to);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_records();
        test_backpressure();
        test_reset_mid_record();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/eng_fmt_tx.md
ENG_FMT_TX -- requirements
Module: eng_fmt_tx

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning width of the unsigned value input (legal 4..32).
REQ-002 The block SHALL have parameter ND, default 5, meaning number of BCD digits held; ND SHALL satisfy 10^ND > 2^W-1.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  request carries a value to format.
REQ-007 in_ready  output  1  block accepts a request this cycle.
REQ-008 in_value  input  W  unsigned mantissa.
REQ-009 in_scale  input  4  SI prefix index: 0=f,1=p,2=n,3=u,4=m,5=none,6=k,7=M,8=G, 9..15 invalid.
REQ-010 in_unit  input  2  unit: 0=none, 1="H", 2="F", 3="Ohm".
REQ-011 out_valid  output  1  out_byte holds a valid character.
REQ-012 out_ready  input  1  sink takes out_byte this cycle.
REQ-013 out_byte  output  8  ASCII character.
REQ-014 out_last  output  1  marks final character of a record.

Function
REQ-015 A request SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; in_value, in_scale, in_unit SHALL be captured there and ignored afterwards.
REQ-016 in_ready SHALL be 1 only in state IDLE.
REQ-017 States: IDLE -> CONV (on accept) -> DIGITS -> SPACE -> PREFIX -> UNIT -> IDLE; SPACE, PREFIX, UNIT SHALL be skipped when they emit nothing.
REQ-018 CONV SHALL perform binary-to-BCD (shift-add-3) one bit per cycle, exactly W cycles; out_valid SHALL rise on cycle W+1 after the accept edge.
REQ-019 DIGITS SHALL emit decimal digits most-significant first, suppressing leading zeros; value 0 SHALL emit the single character "0".
REQ-020 SPACE (0x20) SHALL be emitted iff a prefix or unit follows (in_scale!=5 or in_unit!=0).
REQ-021 PREFIX SHALL emit one character: f,p,n,u,m,k,M,G per REQ-009; nothing for index 5; "?" (0x3F) for indices 9..15.
REQ-022 UNIT SHALL emit "H", "F", or "O","h","m" per REQ-010; nothing for 0.
REQ-023 out_last SHALL be 1 exactly with the final character of the record and 0 otherwise.
REQ-024 A character SHALL advance only on out_valid=1 and out_ready=1; while out_ready=0, out_byte, out_last and out_valid SHALL hold stable.
REQ-025 out_valid SHALL not depend combinationally on out_ready; out_byte SHALL be registered.
REQ-026 After the last character is taken the block SHALL return to IDLE with in_ready=1 on the next cycle; no back-to-back overlap of records.
REQ-027 Maximum value 2^W-1 SHALL format without loss (65535 for W=16).

Reset
REQ-028 While rst_n=0 at a rising edge: state SHALL become IDLE, in_ready SHALL be 1 after the edge, out_valid=0, out_last=0, out_byte=0x00, BCD and capture registers cleared.
REQ-029 Reset mid-record (CONV or any emit state) SHALL abort the record; no remaining characters SHALL be emitted after reset deasserts.
REQ-030 A request presented during reset SHALL NOT be accepted.

Verification
REQ-031 value=50, scale=5, unit=3, out_ready=1 -> "5","0"," ","O","h","m", out_last on "m", first out_valid 17 cycles after accept (W=16).
REQ-032 value=1, scale=4, unit=1 -> "1"," ","m","H"; value=10, scale=5, unit=0 -> "1","0" with out_last on "0", no space.
REQ-033 value=0, scale=12, unit=2 -> "0"," ","?","F".
REQ-034 value=65535, scale=8, unit=0, out_ready toggled 1/0 every cycle -> "6","5","5","3","5"," ","G", bytes stable while stalled, each emitted once.
REQ-035 rst_n=0 for one cycle while emitting second digit of value 123 -> out_valid=0 next cycle, in_ready=1, following request value=7 scale=5 unit=0 -> single "7" with out_last.
